// File: rtl/data_mem_pkg.sv
// Shared constants and types for the byte-wide scratch data memory.
// Define DATA_MEM_CLEAR_ON_RESET_EN to have reset clear the whole array.
package data_mem_pkg;

    localparam int DM_W     = 8;
    localparam int DM_A     = 8;
    localparam int DM_DEPTH = 2 ** DM_A;

    typedef logic [DM_W-1:0] dm_word_t;
    typedef logic [DM_A-1:0] dm_addr_t;

endpackage

// File: rtl/data_memory.sv
// Single-port scratch data memory: combinational read, synchronous write.
// Optional DATA_MEM_CLEAR_ON_RESET_EN: asynchronous clear of mem_core on reset.
module data_memory
    import data_mem_pkg::*;
#(
    parameter int W = DM_W,
    parameter int A = DM_A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] DataAddress,
    input  logic         ReadMem,
    input  logic         WriteMem,
    input  logic [W-1:0] DataIn,
    output logic [W-1:0] DataOut
);

    localparam int DEPTH = 2 ** A;

    // Name and shape are fixed: benches reach this array hierarchically.
    logic [W-1:0] mem_core [0:DEPTH-1];

    logic wr_en;

    always_comb begin
        wr_en = reset & WriteMem;
    end

`ifdef DATA_MEM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_core[i] <= '0;
            end
        end else if (wr_en) begin
            mem_core[DataAddress] <= DataIn;
        end
    end
`else
    // Contents survive reset so bench preloads are kept across a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_core[DataAddress] <= DataIn;
        end
    end
`endif

    always_comb begin
        DataOut = '0;
        if (reset && ReadMem) begin
            DataOut = mem_core[DataAddress];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Expected post-reset contents depend on DATA_MEM_CLEAR_ON_RESET_EN.
module tb_data_memory;

    logic       clk;
    logic       reset;
    logic [7:0] DataAddress;
    logic       ReadMem;
    logic       WriteMem;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    int checks;
    int failures;

    data_memory dut (
        .clk         (clk),
        .reset       (reset),
        .DataAddress (DataAddress),
        .ReadMem     (ReadMem),
        .WriteMem    (WriteMem),
        .DataIn      (DataIn),
        .DataOut     (DataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        DataAddress = a;
        DataIn      = d;
        WriteMem    = 1'b1;
        @(posedge clk);
        #1;
        WriteMem    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a,
                      input logic [7:0] exp);
        DataAddress = a;
        #1;
        check(tag, DataOut, exp);
    endtask

    logic [7:0] exp_keep_10;
    logic [7:0] exp_keep_ff;
    logic [7:0] exp_keep_30;

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        ReadMem     = 1'b1;
        WriteMem    = 1'b0;
        DataAddress = 8'h00;
        DataIn      = 8'h00;
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
        exp_keep_10 = 8'h00;
        exp_keep_ff = 8'h00;
        exp_keep_30 = 8'h00;
`else
        exp_keep_10 = 8'hA5;
        exp_keep_ff = 8'h5A;
        exp_keep_30 = 8'h77;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", DataOut, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        wr(8'h10, 8'hA5);
        ReadMem = 1'b1;
        rd("wr_rd_10", 8'h10, 8'hA5);

        ReadMem = 1'b0;
        rd("rd_dis", 8'h10, 8'h00);
        ReadMem = 1'b1;
        rd("rd_en", 8'h10, 8'hA5);

        @(negedge clk);
        dut.mem_core[8'h20] = 8'h11;
        DataAddress = 8'h20;
        DataIn      = 8'h22;
        WriteMem    = 1'b1;
        #1;
        check("same_pre", DataOut, 8'h11);
        @(posedge clk);
        #1;
        check("same_post", DataOut, 8'h22);
        WriteMem = 1'b0;

        dut.mem_core[0] = 8'h80;
        dut.mem_core[1] = 8'h01;
        rd("bd_0", 8'h00, 8'h80);
        rd("bd_1", 8'h01, 8'h01);
        dut.mem_core[3] = 8'h3C;
        rd("bd_3", 8'h03, 8'h3C);

        ReadMem = 1'b0;
        wr(8'hFF, 8'h5A);
        ReadMem = 1'b1;
        wr(8'h00, 8'hC3);
        rd("bnd_ff", 8'hFF, 8'h5A);
        rd("bnd_00", 8'h00, 8'hC3);
        rd("bnd_01", 8'h01, 8'h01);
        rd("bnd_10", 8'h10, 8'hA5);

        @(negedge clk);
        dut.mem_core[8'h30] = 8'h77;
        DataAddress = 8'h30;
        DataIn      = 8'hFF;
        WriteMem    = 1'b1;
        #1;
        check("mid_pre", DataOut, 8'h77);
        reset = 1'b0;
        #1;
        check("mid_out0", DataOut, 8'h00);
        @(posedge clk);
        #1;
        check("mid_out1", DataOut, 8'h00);
        check("mid_mem30", dut.mem_core[8'h30], exp_keep_30);
        WriteMem = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rd("post_10", 8'h10, exp_keep_10);
        rd("post_ff", 8'hFF, exp_keep_ff);
        rd("post_30", 8'h30, exp_keep_30);

        wr(8'h40, 8'h9E);
        rd("post_wr", 8'h40, 8'h9E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
